// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sweep_pkg
// Brief    : Shared sweep state encoding and vector-count helper.
// Revision : 1.0  initial release
// ============================================================================
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned nvec(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : settle_counter
// Brief    : Modulo-SETTLE cycle counter with synchronous clear and terminal count.
// Revision : 1.0  initial release
// ============================================================================
module settle_counter #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] c_last = CW'(SETTLE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_tc = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Sweeps all N_IN-bit vectors into a combinational DUT, captures its
//            truth table and compares it to a golden table.
//            Optional first-mismatch log: define MISMATCH_LOG_EN.
// Revision : 1.0  initial release
// ============================================================================
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [nvec(N_IN)-1:0]    expected,
    output logic [N_IN-1:0]          dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [nvec(N_IN)-1:0]    table_out
`ifdef MISMATCH_LOG_EN
    ,
    output logic [N_IN-1:0]          first_bad,
    output logic                     bad_valid
`endif
);
    localparam int unsigned     NVEC       = nvec(N_IN);
    localparam logic [N_IN-1:0] c_vec_last = N_IN'(NVEC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_vec;
    logic [NVEC-1:0]   r_table;
    logic [NVEC-1:0]   r_exp;
    logic [NVEC-1:0]   w_table_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              w_tc;
    logic              w_start_acc;
    logic              w_sample;
    logic              w_last;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sample    = (r_state == DRIVE) && w_tc;
    assign w_last      = w_sample && (r_vec == c_vec_last);

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_start_acc),
        .i_en    (r_state == DRIVE),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = DRIVE;
            DRIVE:   if (w_last) w_state_nxt = DONE;
            DONE:    if (start)  w_state_nxt = DRIVE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    // Table including the bit being sampled this cycle, so pass sees the final bit.
    always_comb begin
        w_table_nxt        = r_table;
        w_table_nxt[r_vec] = dut_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vec   <= '0;
            r_table <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_start_acc) begin
            r_vec   <= '0;
            r_table <= '0;
            r_exp   <= expected;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_sample) begin
            r_table <= w_table_nxt;
            if (r_vec == c_vec_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_table_nxt == r_exp);
            end else begin
                r_vec <= r_vec + N_IN'(1);
            end
        end
    end

`ifdef MISMATCH_LOG_EN
    logic [N_IN-1:0] r_first_bad;
    logic            r_bad_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first_bad <= '0;
            r_bad_valid <= 1'b0;
        end else if (w_start_acc) begin
            r_first_bad <= '0;
            r_bad_valid <= 1'b0;
        end else if (w_sample && !r_bad_valid && (dut_out != r_exp[r_vec])) begin
            r_first_bad <= r_vec;
            r_bad_valid <= 1'b1;
        end
    end

    assign first_bad = r_first_bad;
    assign bad_valid = r_bad_valid;
`endif

    assign dut_in    = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign table_out = r_table;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Randomised scoreboard bench for truth_table_sweeper.
// Revision : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;
    localparam int NVEC  = 8;
    localparam int SWEEP = NVEC * 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] expected;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [7:0] table_out;
`ifdef MISMATCH_LOG_EN
    logic [2:0] first_bad;
    logic       bad_valid;
    logic [0:0] first_bad2;
    logic       bad_valid2;
`endif

    logic       start2;
    logic [1:0] expected2;
    logic [0:0] dut_in2;
    logic       dut_out2;
    logic       busy2, done2, pass2;
    logic [1:0] table2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    logic [7:0] fn = 8'h00;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [2:0] fbad;
        logic       bvalid;
        int         e0;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DUT: mode 0 is a = o&~v | l with o = MSB; otherwise a lookup table.
    function automatic logic dut_fn(input int m, input logic [7:0] f, input logic [2:0] v);
        if (m == 0) return (v[2] & ~v[1]) | v[0];
        return f[v];
    endfunction

    assign dut_out  = dut_fn(mode, fn, dut_in);
    assign dut_out2 = ~dut_in2[0];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .expected  (expected),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .table_out (table_out)
`ifdef MISMATCH_LOG_EN
        ,
        .first_bad (first_bad),
        .bad_valid (bad_valid)
`endif
    );

    truth_table_sweeper #(.N_IN(1), .SETTLE(1)) u_small (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start2),
        .expected  (expected2),
        .dut_in    (dut_in2),
        .dut_out   (dut_out2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .table_out (table2)
`ifdef MISMATCH_LOG_EN
        ,
        .first_bad (first_bad2),
        .bad_valid (bad_valid2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] golden();
        logic [7:0] t = '0;
        for (int v = 0; v < NVEC; v++) t[v] = dut_fn(mode, fn, 3'(v));
        return t;
    endfunction

    function automatic item_t make_item(input logic [7:0] e, input int e0);
        item_t it;
        it.tbl    = golden();
        it.pass   = (it.tbl == e);
        it.bvalid = 1'b0;
        it.fbad   = '0;
        for (int v = NVEC - 1; v >= 0; v--) begin
            if (it.tbl[v] != e[v]) begin
                it.bvalid = 1'b1;
                it.fbad   = 3'(v);
            end
        end
        it.e0 = e0;
        return it;
    endfunction

    task automatic launch(input logic [7:0] e);
        @(negedge clk);
        q.push_back(make_item(e, cyc + 1));
        start    = 1'b1;
        expected = e;
        @(negedge clk);
        start    = 1'b0;
        expected = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("sweep_timeout", 1, 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: per-cycle vector check while busy, full result check when done rises.
    initial begin : monitor
        item_t it;
        logic  prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && busy) begin
                if (q.size() == 0) chk("busy_without_start", 1, 0);
                else chk("dut_in_step", 32'(dut_in), 32'((cyc - q[0].e0) / 2));
            end
            if (reset_n && done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("done_without_start", 1, 0);
                end else begin
                    it = q.pop_front();
                    chk("latency", 32'(cyc - it.e0), SWEEP);
                    chk("table_out", 32'(table_out), 32'(it.tbl));
                    chk("pass", 32'(pass), 32'(it.pass));
                    chk("busy_at_done", 32'(busy), 0);
                    chk("dut_in_hold", 32'(dut_in), NVEC - 1);
`ifdef MISMATCH_LOG_EN
                    chk("bad_valid", 32'(bad_valid), 32'(it.bvalid));
                    if (it.bvalid) chk("first_bad", 32'(first_bad), 32'(it.fbad));
`endif
                end
            end
            prev_done = done;
        end
    end

    initial begin : stimulus
        logic [7:0] e;
        int         base;
        int         n;
        reset_n   = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        expected  = '0;
        expected2 = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_table", 32'(table_out), 0);
        chk("rst_dut_in", 32'(dut_in), 0);
`ifdef MISMATCH_LOG_EN
        chk("rst_bad_valid", 32'(bad_valid), 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // o/v/l DUT, matching and then bit-5-flipped golden table
        mode = 0;
        launch(golden());
        wait_idle();
        launch(golden() ^ 8'h20);
        wait_idle();

        // random lookup-table DUTs with mixed expected tables
        for (int k = 0; k < 8; k++) begin
            mode = 1;
            fn   = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       e = fn;
                1:       e = fn ^ (8'd1 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            launch(e);
            wait_idle();
        end

        // start pulses and expected changes mid-sweep are ignored
        fn = 8'($urandom);
        launch(fn);
        repeat (2) @(negedge clk);
        start = 1'b1; expected = ~fn;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; expected = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high: three back-to-back sweeps, done for one cycle between them
        fn = 8'($urandom);
        e  = fn ^ 8'h81;
        @(negedge clk);
        base = cyc + 1;
        for (int k = 0; k < 3; k++) q.push_back(make_item(e, base + k * (SWEEP + 1)));
        start = 1'b1; expected = e;
        repeat (2 * (SWEEP + 1) + 4) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // asynchronous reset mid-sweep discards the partial table
        fn = 8'hFF;
        launch(8'hFF);
        repeat (6) @(negedge clk);
        #1;
        q.delete();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_table", 32'(table_out), 0);
        chk("midrst_dut_in", 32'(dut_in), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fn = 8'($urandom);
        launch(fn);
        wait_idle();

        // N_IN=1, SETTLE=1 instance driving an inverter
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start2    = 1'b1;
            expected2 = (k == 0) ? 2'b01 : 2'b11;
            base      = cyc + 1;
            @(negedge clk);
            start2 = 1'b0;
            n = 0;
            while (!done2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("small_latency", 32'(cyc - base), 2);
            chk("small_table", 32'(table2), 32'(2'b01));
            chk("small_pass", 32'(pass2), (k == 0) ? 1 : 0);
`ifdef MISMATCH_LOG_EN
            chk("small_bad_valid", 32'(bad_valid2), (k == 0) ? 0 : 1);
            if (k == 1) chk("small_first_bad", 32'(first_bad2), 1);
`endif
        end

        repeat (2) @(negedge clk);
        if (q.size() != 0) chk("scoreboard_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
